// File: rtl/seg_pkg.sv
// Shared types and default tuning constants for the rider-presence / steer-enable supervisor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_pkg;

  typedef enum logic [1:0] {OFF = 2'd0, WAIT = 2'd1, STEER = 2'd2} steer_st_t;

  // Weight thresholds are in total-weight units (sum of all cells).
  localparam int MIN_RIDER_WT_DEF = 'h200;
  localparam int WT_HYST_DEF      = 'h040;

  // Settle timer: about 1.34 s at 50 MHz; the fast width keeps simulations short.
  localparam int TMR_W_DEF        = 26;
  localparam int FAST_TMR_W_DEF   = 15;

  // Consecutive bad readings before a cell is declared faulty.
  localparam int FAULT_CNT_DEF    = 8;

endpackage

// File: rtl/steer_supervisor_if.sv
// Sample-in / result-out bundle between the A2D front end and the steer supervisor.
// Latency: n/a (wiring only).
// Backpressure: none; smpl_vld is a strobe and the consumer always accepts.
interface steer_supervisor_if #(
  parameter int N_CELLS = 2,
  parameter int LD_W    = 12
);
  localparam int SUM_W = LD_W + $clog2(N_CELLS / 2);

  logic                      smpl_vld;
  logic [N_CELLS*LD_W-1:0]   ld;
  logic [SUM_W:0]            ld_cell_diff;
  logic [SUM_W:0]            tot_wt;
  logic                      en_steer;
  logic                      rider_off;
  logic [N_CELLS-1:0]        cell_fault;
  logic                      upd;

  // Sample producer side.
  modport master (
    output smpl_vld, ld,
    input  ld_cell_diff, tot_wt, en_steer, rider_off, cell_fault, upd
  );

  // Supervisor side.
  modport slave (
    input  smpl_vld, ld,
    output ld_cell_diff, tot_wt, en_steer, rider_off, cell_fault, upd
  );

endinterface

// File: rtl/ld_cell_flt.sv
// Per-cell stuck/open detector: counts consecutive 0 / all-ones readings, raises a sticky flag.
// Latency: flag sets on the clock that accepts the FAULT_CNT-th consecutive bad reading.
// Backpressure: none; evaluates only on the sample strobe.
module ld_cell_flt
  import seg_pkg::*;
#(
  parameter int LD_W      = 12,
  parameter int FAULT_CNT = FAULT_CNT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_smpl_vld,
  input  logic [LD_W-1:0] i_ld,
  output logic            o_fault
);
  localparam int                CNT_W   = $clog2(FAULT_CNT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FAULT_CNT);

  logic [CNT_W-1:0] r_cnt;
  logic             r_fault;
  logic             w_bad;

  // A shorted cell reads all-ones, an open cell reads zero.
  assign w_bad = (i_ld == '0) || (i_ld == '1);

  // Run-length counter of bad samples; flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else if (i_smpl_vld) begin
      if (!w_bad) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CNT_MAX - 1'b1) r_fault <= 1'b1;
      end
    end
  end

  assign o_fault = r_fault;

endmodule

// File: rtl/steer_supervisor.sv
// Rider-presence and steer-enable supervisor: left/right load sums, weight hysteresis, settle timer.
// Latency: 2 clk from smpl_vld to upd; state/outputs follow upd by 1 and 2 clk.
// Backpressure: none; fully pipelined, a sample may arrive every clock.
module steer_supervisor
  import seg_pkg::*;
#(
  parameter int N_CELLS      = 2,
  parameter int LD_W         = 12,
  parameter int MIN_RIDER_WT = MIN_RIDER_WT_DEF,
  parameter int WT_HYST      = WT_HYST_DEF,
  parameter int TMR_W        = TMR_W_DEF,
  parameter int FAST_TMR_W   = FAST_TMR_W_DEF,
  parameter int FAULT_CNT    = FAULT_CNT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fast_sim,
  steer_supervisor_if.slave   bus
);
  localparam int HALF  = N_CELLS / 2;
  localparam int SUM_W = LD_W + $clog2(HALF);
  localparam int SW1   = SUM_W + 1;

  localparam logic [SUM_W:0]   HI        = SW1'(MIN_RIDER_WT + WT_HYST);
  localparam logic [SUM_W:0]   LO        = SW1'(MIN_RIDER_WT - WT_HYST);
  localparam logic [TMR_W-1:0] FAST_TERM = {{(TMR_W-FAST_TMR_W){1'b0}}, {FAST_TMR_W{1'b1}}};

  logic [N_CELLS-1:0]        w_fault;
  logic [N_CELLS*LD_W-1:0]   w_masked;
  logic [N_CELLS*LD_W-1:0]   r_stg1;
  logic                      r_stg1_vld;
  logic [SUM_W-1:0]          w_lft_sum, w_rght_sum;
  logic [SUM_W-1:0]          r_lft_sum, r_rght_sum;
  logic                      r_upd;
  logic [SUM_W:0]            w_diff, w_tot, w_abs;

  steer_st_t                 r_state, w_state_nxt;
  logic [TMR_W-1:0]          r_tmr, w_tmr_nxt, w_term;
  logic                      w_tmr_done;
  logic                      r_rider_off, r_en_steer;

  // Per-cell fault detectors; a flagged cell contributes zero to the sums.
  for (genvar g = 0; g < N_CELLS; g++) begin : g_cell
    ld_cell_flt #(.LD_W(LD_W), .FAULT_CNT(FAULT_CNT)) u_flt (
      .clk        (clk),
      .rst        (rst),
      .i_smpl_vld (bus.smpl_vld),
      .i_ld       (bus.ld[g*LD_W +: LD_W]),
      .o_fault    (w_fault[g])
    );
    assign w_masked[g*LD_W +: LD_W] = w_fault[g] ? '0 : bus.ld[g*LD_W +: LD_W];
  end

  // Stage 1: capture the (masked) sample set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg1     <= '0;
      r_stg1_vld <= 1'b0;
    end else begin
      r_stg1_vld <= bus.smpl_vld;
      if (bus.smpl_vld) r_stg1 <= w_masked;
    end
  end

  // Zero-extended half sums; SUM_W is sized so these never overflow.
  always_comb begin
    w_lft_sum  = '0;
    w_rght_sum = '0;
    for (int i = 0; i < HALF; i++) begin
      w_lft_sum  = w_lft_sum  + SUM_W'(r_stg1[i*LD_W +: LD_W]);
      w_rght_sum = w_rght_sum + SUM_W'(r_stg1[(i+HALF)*LD_W +: LD_W]);
    end
  end

  // Stage 2: register the half sums; upd marks the cycle they are fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lft_sum  <= '0;
      r_rght_sum <= '0;
      r_upd      <= 1'b0;
    end else begin
      r_upd <= r_stg1_vld;
      if (r_stg1_vld) begin
        r_lft_sum  <= w_lft_sum;
        r_rght_sum <= w_rght_sum;
      end
    end
  end

  assign w_diff     = {1'b0, r_lft_sum} - {1'b0, r_rght_sum};
  assign w_tot      = {1'b0, r_lft_sum} + {1'b0, r_rght_sum};
  assign w_abs      = w_diff[SUM_W] ? ('0 - w_diff) : w_diff;
  assign w_term     = fast_sim ? FAST_TERM : {TMR_W{1'b1}};
  assign w_tmr_done = (r_tmr >= w_term);

  // State and settle-timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OFF;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  // Next state: weight-low wins over imbalance, imbalance wins over timer expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    case (r_state)
      OFF: begin
        w_tmr_nxt = '0;
        if (r_upd && (w_tot > HI)) w_state_nxt = WAIT;
      end
      WAIT: begin
        w_tmr_nxt = w_tmr_done ? r_tmr : r_tmr + 1'b1;
        if (r_upd) begin
          if (w_tot < LO) begin
            w_state_nxt = OFF;
            w_tmr_nxt   = '0;
          end else if (w_abs > (w_tot >> 2)) begin
            w_tmr_nxt   = '0;
          end else if (w_tmr_done) begin
            w_state_nxt = STEER;
          end
        end
      end
      STEER: begin
        if (r_upd) begin
          if (w_tot < LO) begin
            w_state_nxt = OFF;
            w_tmr_nxt   = '0;
          end else if (w_abs > (w_tot - (w_tot >> 4))) begin
            // One foot lifted: back to settling.
            w_state_nxt = WAIT;
            w_tmr_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = OFF;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  // Registered status; any faulty cell vetoes steering without touching the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rider_off <= 1'b1;
      r_en_steer  <= 1'b0;
    end else begin
      r_rider_off <= (r_state == OFF);
      r_en_steer  <= (r_state == STEER) && !(|w_fault);
    end
  end

  assign bus.ld_cell_diff = w_diff;
  assign bus.tot_wt       = w_tot;
  assign bus.upd          = r_upd;
  assign bus.rider_off    = r_rider_off;
  assign bus.en_steer     = r_en_steer;
  assign bus.cell_fault   = w_fault;

endmodule

// File: tb/tb_steer_supervisor.sv
// Randomized and directed bench for steer_supervisor with a queue scoreboard and a reference model.
// Latency: samples expected on upd 2 clk after the strobe.
// Backpressure: none.
`timescale 1ns/1ps
module tb_steer_supervisor;
  import seg_pkg::*;

  localparam int LD_W = 12;
  localparam int TERM = 32767;
  localparam int HI   = 'h240;
  localparam int LO   = 'h1C0;
  localparam int BIG  = 1 << 30;

  typedef struct {
    int due;
    int diff;
    int tot;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fast_sim = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  exp_t q2[$];
  exp_t q4[$];
  int   run[2];
  int   fset[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  steer_supervisor_if #(.N_CELLS(2), .LD_W(LD_W)) bus2();
  steer_supervisor_if #(.N_CELLS(4), .LD_W(LD_W)) bus4();

  steer_supervisor #(.N_CELLS(2), .LD_W(LD_W)) dut2 (
    .clk(clk), .rst(rst), .fast_sim(fast_sim), .bus(bus2)
  );
  steer_supervisor #(.N_CELLS(4), .LD_W(LD_W)) dut4 (
    .clk(clk), .rst(rst), .fast_sim(fast_sim), .bus(bus4)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One sample to the 2-cell DUT; the model predicts masking, faults and sums.
  task automatic send2(input logic [11:0] c0, input logic [11:0] c1);
    int   cap;
    int   v[2];
    logic [11:0] c[2];
    exp_t e;
    c[0] = c0;
    c[1] = c1;
    cap = cyc + 1;
    bus2.smpl_vld = 1'b1;
    bus2.ld       = {c1, c0};
    for (int i = 0; i < 2; i++) begin
      v[i] = (fset[i] <= cap - 1) ? 0 : int'(c[i]);
      if (c[i] == 12'h000 || c[i] == 12'hFFF) begin
        run[i]++;
        if (run[i] == 8 && fset[i] == BIG) fset[i] = cap;
      end else begin
        run[i] = 0;
      end
    end
    e.due  = cap + 1;
    e.diff = v[0] - v[1];
    e.tot  = v[0] + v[1];
    q2.push_back(e);
    @(posedge clk);
    #1;
    bus2.smpl_vld = 1'b0;
  endtask

  task automatic clear_model();
    q2.delete();
    q4.delete();
    for (int i = 0; i < 2; i++) begin
      run[i]  = 0;
      fset[i] = BIG;
    end
  endtask

  // Monitor for the 2-cell DUT: scoreboard pop on upd plus a cycle-stamped rider model.
  initial begin
    steer_st_t s_prev, s_cur, s_nxt;
    int   clr, n, ad, tv, tmr;
    logic up;
    logic [1:0] f_now, f_prev;
    exp_t e;
    s_prev = OFF;
    s_cur  = OFF;
    clr    = 0;
    forever begin
      @(negedge clk);
      n = cyc;
      if (rst) begin
        s_prev = OFF;
        s_cur  = OFF;
      end else begin
        f_now  = {fset[1] <= n,     fset[0] <= n};
        f_prev = {fset[1] <= n - 1, fset[0] <= n - 1};
        chk("rider_off", bus2.rider_off, s_prev == OFF);
        chk("en_steer", bus2.en_steer, (s_prev == STEER) && (f_prev == 2'b00));
        chk("cell_fault", bus2.cell_fault, f_now);
        while (q2.size() > 0 && q2[0].due < n) begin
          chk("upd_missing", 0, 1);
          e = q2.pop_front();
        end
        up = (q2.size() > 0) && (q2[0].due == n);
        chk("upd", bus2.upd, up);
        s_nxt = s_cur;
        if (up) begin
          e = q2.pop_front();
          chk("ld_cell_diff", longint'($signed(bus2.ld_cell_diff)), e.diff);
          chk("tot_wt", bus2.tot_wt, e.tot);
          ad  = (e.diff < 0) ? -e.diff : e.diff;
          tv  = e.tot;
          tmr = (n - clr > TERM) ? TERM : n - clr;
          case (s_cur)
            OFF: if (tv > HI) begin
              s_nxt = WAIT;
              clr   = n + 1;
            end
            WAIT: begin
              if (tv < LO) s_nxt = OFF;
              else if (ad > tv / 4) clr = n + 1;
              else if (tmr == TERM) s_nxt = STEER;
            end
            STEER: begin
              if (tv < LO) s_nxt = OFF;
              else if (ad > tv - tv / 16) begin
                s_nxt = WAIT;
                clr   = n + 1;
              end
            end
            default: s_nxt = OFF;
          endcase
        end
        s_prev = s_cur;
        s_cur  = s_nxt;
      end
    end
  end

  // Monitor for the 4-cell DUT: sums and upd timing only.
  initial begin
    exp_t e;
    logic up;
    forever begin
      @(negedge clk);
      if (!rst) begin
        while (q4.size() > 0 && q4[0].due < cyc) begin
          chk("upd4_missing", 0, 1);
          e = q4.pop_front();
        end
        up = (q4.size() > 0) && (q4[0].due == cyc);
        chk("upd4", bus4.upd, up);
        if (up) begin
          e = q4.pop_front();
          chk("ld_cell_diff4", longint'($signed(bus4.ld_cell_diff)), e.diff);
          chk("tot_wt4", bus4.tot_wt, e.tot);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    chk("timeout", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [11:0] a, b;
    logic [11:0] c4[4];
    exp_t e4;

    clear_model();
    bus2.smpl_vld = 1'b0;
    bus2.ld       = {12'h300, 12'h300};
    bus4.smpl_vld = 1'b0;
    bus4.ld       = {4{12'h300}};
    rst = 1'b1;
    idle(3);
    chk("rst_rider_off", bus2.rider_off, 1);
    chk("rst_en_steer", bus2.en_steer, 0);
    chk("rst_cell_fault", bus2.cell_fault, 0);
    chk("rst_upd", bus2.upd, 0);
    rst = 1'b0;
    idle(2);

    // First sample after reset; monitor verifies upd lands exactly 2 clk later.
    send2(12'h100, 12'h080);
    idle(4);

    // Continuous strobe on the 4-cell instance.
    for (int k = 0; k < 200; k++) begin
      for (int i = 0; i < 4; i++)
        c4[i] = (k == 0) ? 12'hFFE : 12'($urandom_range(1, 'hFFE));
      bus4.smpl_vld = 1'b1;
      bus4.ld       = {c4[3], c4[2], c4[1], c4[0]};
      e4.due  = cyc + 2;
      e4.diff = (int'(c4[0]) + int'(c4[1])) - (int'(c4[2]) + int'(c4[3]));
      e4.tot  = int'(c4[0]) + int'(c4[1]) + int'(c4[2]) + int'(c4[3]);
      q4.push_back(e4);
      idle(1);
    end
    bus4.smpl_vld = 1'b0;
    idle(4);

    // Random samples with random spacing, including back-to-back.
    repeat (300) begin
      if ($urandom_range(0, 1) == 1) begin
        a = 12'($urandom_range(0, 'h200));
        b = 12'($urandom_range(0, 'h200));
      end else begin
        a = 12'($urandom_range(0, 'hFFF));
        b = 12'($urandom_range(0, 'hFFF));
      end
      send2(a, b);
      idle($urandom_range(0, 3));
    end
    idle(4);

    // Mid-operation reset with a sample in flight.
    send2(12'h300, 12'h300);
    idle(3);
    send2(12'h2AA, 12'h155);
    rst = 1'b1;
    clear_model();
    #1;
    chk("arst_rider_off", bus2.rider_off, 1);
    chk("arst_en_steer", bus2.en_steer, 0);
    chk("arst_upd", bus2.upd, 0);
    chk("arst_tot_wt", bus2.tot_wt, 0);
    chk("arst_diff", bus2.ld_cell_diff, 0);
    idle(2);
    rst = 1'b0;
    idle(6);

    // Exactly at the upper threshold: must stay OFF.
    repeat (3) begin
      send2(12'h120, 12'h120);
      idle(15);
    end
    chk("hi_edge_rider_off", bus2.rider_off, 1);

    // Mount, one imbalanced sample mid-settle, then settle to STEER.
    for (int k = 0; k < 2661; k++) begin
      if (k == 600) send2(12'h010, 12'h300);
      else send2(12'h180, 12'h180);
      idle(15);
      if (k == 0) begin
        chk("mount_tot_wt", bus2.tot_wt, 'h300);
        chk("mount_rider_off", bus2.rider_off, 0);
      end
      if (k == 599) chk("pre_imb_en_steer", bus2.en_steer, 0);
    end
    chk("mount_en_steer", bus2.en_steer, 1);

    // Inside the hysteresis band: stays in STEER.
    repeat (3) begin
      send2(12'h0E8, 12'h0E8);
      idle(15);
    end
    chk("hyst_en_steer", bus2.en_steer, 1);

    // Cell 1 shorted for 8 samples while steering.
    repeat (8) begin
      send2(12'h180, 12'hFFF);
      idle(15);
    end
    chk("fault_flag", bus2.cell_fault, 2'b10);
    chk("fault_en_steer", bus2.en_steer, 0);

    // Dismount with cell 1 excluded from the total.
    send2(12'h1B0, 12'h0E8);
    idle(3);
    chk("dismount_tot_wt", bus2.tot_wt, 'h1B0);
    chk("dismount_rider_off", bus2.rider_off, 1);
    repeat (4) begin
      send2(12'h180, 12'h180);
      idle(3);
    end
    chk("fault_sticky", bus2.cell_fault, 2'b10);
    chk("excl_tot_wt", bus2.tot_wt, 'h180);

    rst = 1'b1;
    clear_model();
    #1;
    chk("final_rst_fault", bus2.cell_fault, 0);
    chk("final_rst_rider_off", bus2.rider_off, 1);
    idle(2);
    rst = 1'b0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
